spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Single-clock SPI slave endpoint that sits directly downstream of the team's SPI master. It sits on one `ss` line and receives the master's 16-bit MSB-first words on `mosi` while returning a preloaded 16-bit word on `miso`. It oversamples `sclk`/`ss_n`/`mosi` with the system clock, supports all four CPOL/CPHA modes, delivers each received word with a one-cycle strobe, and supports back-to-back words within one `ss_n` low period.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `ss_n`, `mosi`; legal values 2–3.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `spi_mode`  in  2  [1]=CPOL, [0]=CPHA; latched on each detected `ss_n` fall and ignored otherwise.
- `sclk`  in  1  SPI clock from the master (asynchronous).
- `ss_n`  in  1  slave select, active low (asynchronous).
- `mosi`  in  1  serial data in (asynchronous).
- `miso`  out  1  serial data out; `tx_shift[15]` while selected, 0 otherwise (no tristate).
- `tx_data`  in  16  word to return to the master.
- `tx_load`  in  1  one-cycle strobe; writes `tx_data` into `tx_buf`.
- `tx_ready`  out  1  1 when `tx_buf` has been consumed into the shifter and can take a new word.
- `rx_data`  out  16  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle strobe when `rx_data` updates.
- `frame_err`  out  1  one-cycle strobe when `ss_n` rises with a partial word, i.e. `bit_cnt` not equal to 0.

## Operation
- Input conditioning:
  - `SYNC_STAGES`-flop synchronizer on each asynchronous input, plus one history flop on `sclk_s` and `ss_s`.
  - Rise and fall events are detected from the history flop versus the synchronized value.
- Edge roles, with CPOL as latched:
  - Leading edge: rise if CPOL=0, fall if CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- States:
  - WAIT_IDLE (reset state): go to IDLE once `ss_s`=1 has been observed. A frame already in progress at reset is therefore ignored.
  - IDLE: on an `ss_s` fall:
    - latch `spi_mode`, set `bit_cnt`=0;
    - load `tx_shift` from `tx_buf` and set `tx_ready`=1;
    - go to ACTIVE.
  - ACTIVE, on a sample edge: `rx_shift <= {rx_shift[14:0], mosi_s}`, `bit_cnt` increments. On the 16th sample:
    - `rx_data <= {rx_shift[14:0], mosi_s}`, `rx_valid` pulses;
    - `bit_cnt` wraps to 0 and `word_start` is set.
  - ACTIVE, on a shift edge:
    - If `word_start`=1, reload `tx_shift` from `tx_buf`, set `tx_ready`=1 and clear `word_start`. Otherwise shift `tx_shift` left by 1, filling with 0.
    - CPHA=0: `word_start` is cleared at the `ss` fall, because bit 15 is already loaded.
    - CPHA=1: `word_start` is set at the `ss` fall, so the first leading edge performs the load.
  - ACTIVE, on an `ss_s` rise: pulse `frame_err` if `bit_cnt`≠0 and discard the partial word; go to IDLE.
- TX buffer:
  - `tx_load` writes `tx_buf` and clears `tx_ready`, even when `tx_ready`=0 (the old word is overwritten).
  - If a reload occurs while `tx_ready`=1, the stale `tx_buf` is sent again.
  - If `tx_load` and a reload occur in the same cycle, `tx_data` goes straight into `tx_shift` and `tx_buf`, and `tx_ready` ends at 1.
- Edge priority within one cycle: an `ss_s` rise wins over a coincident `sclk_s` edge; that `sclk` edge is dropped.
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `tx_ready`=1, `tx_buf`=0, `tx_shift`=0, `bit_cnt`=0, state=WAIT_IDLE.
- A reset asserted mid-frame takes effect on the next `clk` edge and returns the block to WAIT_IDLE.

## Timing
- Edge detection latency: `SYNC_STAGES`+1 `clk` cycles from a pin transition to the internal event (3 cycles at the default).
- `rx_valid` is asserted in the cycle after the 16th sample event. `rx_data` is valid in that same cycle.
- `miso` changes in the cycle after a shift event or after the `ss` fall event.
- Required `sclk` high time and low time: each ≥ 4 `clk` periods.
- Required `ss_n` setup to the first `sclk` edge, and hold after the last `sclk` edge: ≥ 4 `clk` periods.
- `spi_mode` must be stable for `SYNC_STAGES`+2 cycles around the `ss_n` fall.
- Maximum sustained word rate: one `rx_valid` per 16 `sclk` periods; no gap is needed between words.

## Test plan
- Mode 0, `tx_load` 0xA5C3 then a frame where the master sends 0x1234: `rx_valid` pulses once, `rx_data`=0x1234, the master captures 0xA5C3, and `tx_ready` returns to 1 at the `ss` fall.
- Modes 1, 2 and 3, each sending 0xFFFF, 0x0000 and 0x8001: `rx_data` matches each word, and `miso` data is correct with respect to each mode's sampling edge.
- Two back-to-back words 0xBEEF, 0xCAFE under one `ss_n` low, with `tx_load` of 0x0F0F during the first word: two `rx_valid` pulses in order, and the master receives the first word's `tx_buf` value followed by 0x0F0F.
- `ss_n` rises after 7 bits: `frame_err` pulses once, there is no `rx_valid`, and `rx_data` is unchanged. The next full frame of 0x5555 is received correctly.
- `rst` asserted at bit 9 of a frame: all outputs return to their reset values on the next `clk`. The rest of that frame produces no `rx_valid`. The next frame is received normally.
- `tx_load` in the same cycle as a word-boundary reload with `tx_data`=0x3C3C: the next word sent is 0x3C3C and `tx_ready`=1 afterwards.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversampled sclk/ss_n/mosi, all four CPOL/CPHA modes,
// 16-bit MSB-first words in both directions with back-to-back word support.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  spi_mode,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic        sclk_d, ss_d;
  logic        sclk_s, ss_s, mosi_s;
  logic        cpol, cpha;
  logic        word_start;
  logic [3:0]  bit_cnt;
  logic [15:0] rx_shift, tx_shift, tx_shift_nxt, tx_buf;
  logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic        lead_ev, trail_ev, in_frame, sample_ev, shift_ev, start_ev, reload;

  // ss chain resets low so WAIT_IDLE only leaves on a genuinely deselected bus
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign lead_ev   = cpol ? sclk_fall : sclk_rise;
  assign trail_ev  = cpol ? sclk_rise : sclk_fall;
  // a deselect in the same cycle swallows any coincident sclk edge
  assign in_frame  = (state == ACTIVE) && !ss_rise;
  assign sample_ev = in_frame && (cpha ? trail_ev : lead_ev);
  assign shift_ev  = in_frame && (cpha ? lead_ev : trail_ev);
  assign start_ev  = (state == IDLE) && ss_fall;
  assign reload    = start_ev || (shift_ev && word_start);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (ss_s)    state_nxt = IDLE;      else state_nxt = WAIT_IDLE;
      IDLE:      if (ss_fall) state_nxt = ACTIVE;    else state_nxt = IDLE;
      ACTIVE:    if (ss_rise) state_nxt = IDLE;      else state_nxt = ACTIVE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // a tx_load coinciding with a reload bypasses tx_buf straight into the shifter
  always_comb begin
    tx_shift_nxt = tx_shift;
    if (reload) begin
      if (tx_load) tx_shift_nxt = tx_data;
      else         tx_shift_nxt = tx_buf;
    end else if (shift_ev) begin
      tx_shift_nxt = {tx_shift[14:0], 1'b0};
    end else begin
      tx_shift_nxt = tx_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso       <= 1'b0;
      rx_data    <= 16'h0000;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      tx_ready   <= 1'b1;
      tx_buf     <= 16'h0000;
      tx_shift   <= 16'h0000;
      rx_shift   <= 16'h0000;
      bit_cnt    <= 4'd0;
      word_start <= 1'b0;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tx_load) tx_buf <= tx_data;
      if (reload)       tx_ready <= 1'b1;
      else if (tx_load) tx_ready <= 1'b0;
      tx_shift <= tx_shift_nxt;
      miso     <= (state_nxt == ACTIVE) & tx_shift_nxt[15];
      if (start_ev) begin
        cpol       <= spi_mode[1];
        cpha       <= spi_mode[0];
        bit_cnt    <= 4'd0;
        // with CPHA=1 the first leading edge performs the word load
        word_start <= spi_mode[0];
      end else if ((state == ACTIVE) && ss_rise) begin
        frame_err  <= (bit_cnt != 4'd0);
        bit_cnt    <= 4'd0;
        word_start <= 1'b0;
      end else if (sample_ev) begin
        rx_shift <= {rx_shift[14:0], mosi_s};
        if (bit_cnt == 4'd15) begin
          rx_data    <= {rx_shift[14:0], mosi_s};
          rx_valid   <= 1'b1;
          bit_cnt    <= 4'd0;
          word_start <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (shift_ev && word_start) begin
        word_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: bench acts as SPI master; received
// words are scoreboarded and checked when rx_valid fires.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  spi_mode = 2'b00;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int rv_count = 0;
  int fe_count = 0;
  logic [15:0] rx_q[$];
  logic [15:0] last_rx = 16'h0000;
  logic [1:0]  cur_mode = 2'b00;

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_mode(spi_mode), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (rx_valid) begin
      rv_count++;
      vectors++;
      if (rx_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%h, required no word", rx_data);
      end else begin
        logic [15:0] exp;
        exp = rx_q.pop_front();
        if (rx_data !== exp) begin
          miscompares++;
          $display("FAIL rx_data: got %h required %h", rx_data, exp);
        end
      end
    end
    if (frame_err) fe_count++;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_half(input bit ld, input logic [15:0] v);
    if (ld) begin
      tx_data = v; tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (7) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    tx_data = v; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic ss_low(input logic [1:0] m);
    cur_mode = m; spi_mode = m; sclk = m[1]; mosi = 1'b0;
    repeat (8) @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] word, input int nbits, input int ld_bit,
                      input logic [15:0] ld_val, output logic [15:0] cap);
    logic cpol, cpha;
    cpol = cur_mode[1]; cpha = cur_mode[0];
    cap = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = word[15-i];
        wait_half(i == ld_bit, ld_val);
        sclk = ~cpol;
        cap = {cap[14:0], miso};
        wait_half(1'b0, 16'h0000);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = word[15-i];
        wait_half(i == ld_bit, ld_val);
        sclk = cpol;
        cap = {cap[14:0], miso};
        wait_half(1'b0, 16'h0000);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_miso", {15'h0, miso}, 16'h0000);
    chk("reset_rx_data", rx_data, 16'h0000);
    chk("reset_rx_valid", {15'h0, rx_valid}, 16'h0000);
    chk("reset_frame_err", {15'h0, frame_err}, 16'h0000);
    chk("reset_tx_ready", {15'h0, tx_ready}, 16'h0001);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [15:0] cap;
    int rv0;
    do_load(16'hA5C3);
    chk("m0_tx_ready_after_load", {15'h0, tx_ready}, 16'h0000);
    rx_q.push_back(16'h1234);
    rv0 = rv_count;
    ss_low(2'b00);
    chk("m0_tx_ready_at_ss_fall", {15'h0, tx_ready}, 16'h0001);
    xfer(16'h1234, 16, -1, 16'h0000, cap);
    ss_high();
    chk("m0_miso_word", cap, 16'hA5C3);
    chk("m0_rx_valid_count", 16'(rv_count - rv0), 16'h0001);
    last_rx = 16'h1234;
  endtask

  task automatic test_modes();
    logic [15:0] words[3];
    logic [15:0] cap, tx;
    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h8001;
    for (int m = 1; m < 4; m++) begin
      for (int k = 0; k < 3; k++) begin
        tx = words[k] ^ 16'h5A5A;
        do_load(tx);
        rx_q.push_back(words[k]);
        ss_low(2'(m));
        xfer(words[k], 16, -1, 16'h0000, cap);
        ss_high();
        chk($sformatf("mode%0d_miso_%0d", m, k), cap, tx);
        last_rx = words[k];
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap1, cap2;
    int rv0;
    do_load(16'h1357);
    rx_q.push_back(16'hBEEF);
    rx_q.push_back(16'hCAFE);
    rv0 = rv_count;
    ss_low(2'b00);
    xfer(16'hBEEF, 16, 4, 16'h0F0F, cap1);
    xfer(16'hCAFE, 16, -1, 16'h0000, cap2);
    ss_high();
    chk("b2b_miso_word1", cap1, 16'h1357);
    chk("b2b_miso_word2", cap2, 16'h0F0F);
    chk("b2b_rx_valid_count", 16'(rv_count - rv0), 16'h0002);
    last_rx = 16'hCAFE;
  endtask

  task automatic test_frame_err();
    logic [15:0] cap;
    int rv0, fe0;
    rv0 = rv_count; fe0 = fe_count;
    ss_low(2'b00);
    xfer(16'h6B3D, 7, -1, 16'h0000, cap);
    ss_high();
    chk("ferr_pulse_count", 16'(fe_count - fe0), 16'h0001);
    chk("ferr_no_rx_valid", 16'(rv_count - rv0), 16'h0000);
    chk("ferr_rx_data_held", rx_data, last_rx);
    do_load(16'h2468);
    rx_q.push_back(16'h5555);
    ss_low(2'b00);
    xfer(16'h5555, 16, -1, 16'h0000, cap);
    ss_high();
    chk("ferr_next_miso", cap, 16'h2468);
    last_rx = 16'h5555;
  endtask

  task automatic test_mid_reset();
    logic [15:0] cap, w;
    int rv0, fe0;
    w = 16'hF0F0;
    do_load(16'h1111);
    ss_low(2'b00);
    xfer(w, 9, -1, 16'h0000, cap);
    rv0 = rv_count; fe0 = fe_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_miso", {15'h0, miso}, 16'h0000);
    chk("rst_rx_data", rx_data, 16'h0000);
    chk("rst_rx_valid", {15'h0, rx_valid}, 16'h0000);
    chk("rst_frame_err", {15'h0, frame_err}, 16'h0000);
    chk("rst_tx_ready", {15'h0, tx_ready}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    xfer(w << 9, 7, -1, 16'h0000, cap);
    ss_high();
    chk("rst_rest_no_rx_valid", 16'(rv_count - rv0), 16'h0000);
    chk("rst_rest_no_frame_err", 16'(fe_count - fe0), 16'h0000);
    do_load(16'hC001);
    rx_q.push_back(16'h9ABC);
    ss_low(2'b00);
    xfer(16'h9ABC, 16, -1, 16'h0000, cap);
    ss_high();
    chk("rst_next_miso", cap, 16'hC001);
    last_rx = 16'h9ABC;
  endtask

  task automatic test_same_cycle_load();
    logic [15:0] cap1, cap2;
    do_load(16'h7E81);
    rx_q.push_back(16'h0101);
    rx_q.push_back(16'h0202);
    ss_low(2'b00);
    xfer(16'h0101, 16, -1, 16'h0000, cap1);
    // the reload event lands on the third rising clk edge after the trailing sclk edge
    @(negedge clk);
    @(negedge clk);
    tx_data = 16'h3C3C; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    chk("same_cycle_tx_ready", {15'h0, tx_ready}, 16'h0001);
    xfer(16'h0202, 16, -1, 16'h0000, cap2);
    ss_high();
    chk("same_cycle_word1", cap1, 16'h7E81);
    chk("same_cycle_word2", cap2, 16'h3C3C);
    last_rx = 16'h0202;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_frame_err();
    test_mid_reset();
    test_same_cycle_load();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 16'(rx_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
